// File: rtl/furv_mem_responder_if.sv
// Bus bundle between the furv core data port / console UART and the memory responder.
// tx_valid/tx_ready: a byte transfers on every rising edge where both are high; tx_valid never waits on tx_ready.
interface furv_mem_responder_if;
  logic        mem_en;
  logic        mem_read;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_en, mem_read, addr, wdata, tx_ready,
    input  rdata, tx_data, tx_valid
  );

  modport slave (
    input  mem_en, mem_read, addr, wdata, tx_ready,
    output rdata, tx_data, tx_valid
  );
endinterface

// File: rtl/furv_mem_responder.sv
// Memory-side responder for the furv data bus: word RAM plus MMIO block
// (console TX FIFO, cycle counter, GPIO, status). Single-edge, zero-wait-state access.
module furv_mem_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  furv_mem_responder_if.slave  bus,
  output logic [31:0]          gpio,
  output logic                 err
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [29:0]      RAM_LIMIT = 30'(RAM_WORDS);
  localparam logic [CNT_W-1:0] FIFO_MAX  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] REG_CONSOLE = 2'd0;
  localparam logic [1:0] REG_CYCLE   = 2'd1;
  localparam logic [1:0] REG_GPIO    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [31:0]        mem [RAM_WORDS];
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        cycle;
  logic               overflow;

  logic              req, rd_req, wr_req;
  logic              ram_hit, mmio_hit, unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        reg_sel;
  logic              fifo_full, fifo_empty;
  logic              push_req, push, pop, ovf_set;
  logic              status_wr, gpio_wr, ram_we, err_set;
  logic [31:0]       status_word, rd_val;

  // A request sampled while rst is high is discarded entirely.
  assign req    = bus.mem_en && !rst;
  assign rd_req = req && bus.mem_read;
  assign wr_req = req && !bus.mem_read;

  assign ram_hit  = (bus.addr < MMIO_BASE) && (bus.addr[31:2] < RAM_LIMIT);
  assign mmio_hit = (bus.addr[31:4] == MMIO_BASE[31:4]);
  assign unmapped = !ram_hit && !mmio_hit;
  assign ram_idx  = bus.addr[RAM_AW+1:2];
  assign reg_sel  = bus.addr[3:2];

  assign fifo_full  = (count == FIFO_MAX);
  assign fifo_empty = (count == '0);
  assign push_req   = wr_req && mmio_hit && (reg_sel == REG_CONSOLE);
  // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign push       = push_req && !fifo_full;
  assign ovf_set    = push_req && fifo_full;
  assign pop        = !fifo_empty && bus.tx_ready;

  assign status_wr = wr_req && mmio_hit && (reg_sel == REG_STATUS);
  assign gpio_wr   = wr_req && mmio_hit && (reg_sel == REG_GPIO);
  assign ram_we    = wr_req && ram_hit;
  assign err_set   = req && unmapped;

  assign status_word = {16'h0000, 8'(count), 4'h0, err, overflow, fifo_empty, fifo_full};

  assign bus.tx_data  = fifo_mem[rd_ptr];
  assign bus.tx_valid = !fifo_empty;

  always_comb begin
    rd_val = 32'h0;
    if (ram_hit) begin
      rd_val = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_CONSOLE: rd_val = 32'h0;
        REG_CYCLE:   rd_val = cycle;
        REG_GPIO:    rd_val = gpio;
        REG_STATUS:  rd_val = status_word;
        default:     rd_val = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= 32'h0;
      gpio      <= 32'h0;
      cycle     <= 32'h0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (rd_req) bus.rdata <= rd_val;
      if (gpio_wr) gpio <= bus.wdata;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // W1C clears lose against a set on the same edge.
      overflow <= ovf_set | (overflow & !(status_wr && bus.wdata[2]));
      err      <= err_set | (err & !(status_wr && bus.wdata[3]));
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.wdata[7:0];
  end

endmodule

// File: tb/tb_furv_mem_responder.sv
// Directed bench for furv_mem_responder: requests driven on the falling edge, results sampled on the next falling edge.
module tb_furv_mem_responder;

  localparam logic [31:0] CONSOLE = 32'h8000_0000;
  localparam logic [31:0] CYCLE   = 32'h8000_0004;
  localparam logic [31:0] GPIO    = 32'h8000_0008;
  localparam logic [31:0] STATUS  = 32'h8000_000C;

  logic        clk;
  logic        rst;
  logic [31:0] gpio;
  logic        err;
  int          errors;
  int          checks;

  furv_mem_responder_if bus ();

  furv_mem_responder #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'h8000_0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .gpio (gpio),
    .err  (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; request is sampled on the following rising edge.
  task automatic do_req(input logic rd, input logic [31:0] a, input logic [31:0] d);
    bus.mem_en   = 1'b1;
    bus.mem_read = rd;
    bus.addr     = a;
    bus.wdata    = d;
    @(negedge clk);
    bus.mem_en   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    do_req(1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.mem_en   = 1'b0;
    bus.mem_read = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    bus.tx_ready = 1'b0;
    idle(3);
    rst = 1'b0;

    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_gpio", gpio, 32'h0);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);

    // Cycle counter: read sampled on the 5th rising edge after reset
    idle(4);
    rd(CYCLE);
    check("cycle_5th_edge", bus.rdata, 32'd4);
    force dut.cycle = 32'hFFFF_FFFF;
    #1;
    release dut.cycle;
    rd(CYCLE);
    check("cycle_max", bus.rdata, 32'hFFFF_FFFF);
    rd(CYCLE);
    check("cycle_wrap", bus.rdata, 32'h0);

    // RAM round trip
    wr(32'h0000_0014, 32'h0000_0000);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0013);
    check("ram_read_10", bus.rdata, 32'hDEAD_BEEF);
    wr(32'h0000_0018, 32'h0000_0055);
    check("write_keeps_rdata", bus.rdata, 32'hDEAD_BEEF);
    idle(2);
    check("idle_keeps_rdata", bus.rdata, 32'hDEAD_BEEF);
    rd(32'h0000_0014);
    check("ram_read_14", bus.rdata, 32'h0);
    wr(32'h0000_0FFC, 32'hA5A5_5A5A);
    rd(32'h0000_0FFC);
    check("ram_last_word", bus.rdata, 32'hA5A5_5A5A);
    check("ram_no_err", 32'(err), 32'h0);

    // FIFO fill past capacity, then drain
    for (int i = 0; i < 9; i++) wr(CONSOLE, 32'h41 + 32'(i));
    rd(STATUS);
    check("status_full_ovf", bus.rdata, 32'h0000_0805);
    check("fill_head", 32'(bus.tx_data), 32'h41);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(bus.tx_valid), 32'h1);
      check("drain_data", 32'(bus.tx_data), 32'h41 + 32'(i));
      @(negedge clk);
    end
    check("drain_empty", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;
    rd(STATUS);
    check("status_empty_ovf", bus.rdata, 32'h0000_0006);
    wr(STATUS, 32'h0000_0004);
    rd(STATUS);
    check("status_ovf_cleared", bus.rdata, 32'h0000_0002);
    rd(CONSOLE);
    check("console_read_zero", bus.rdata, 32'h0);

    // Simultaneous push and pop at count 3
    wr(CONSOLE, 32'h61);
    wr(CONSOLE, 32'h62);
    wr(CONSOLE, 32'h63);
    bus.tx_ready = 1'b1;
    wr(CONSOLE, 32'h64);
    bus.tx_ready = 1'b0;
    rd(STATUS);
    check("status_count3", bus.rdata, 32'h0000_0300);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("pp_data", 32'(bus.tx_data), 32'h62 + 32'(i));
      @(negedge clk);
    end
    check("pp_empty", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;

    // Push at count 8 with pop on the same edge: byte dropped
    for (int i = 0; i < 8; i++) wr(CONSOLE, 32'h30 + 32'(i));
    bus.tx_ready = 1'b1;
    wr(CONSOLE, 32'h58);
    bus.tx_ready = 1'b0;
    rd(STATUS);
    check("status_full_pop", bus.rdata, 32'h0000_0704);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("fp_data", 32'(bus.tx_data), 32'h31 + 32'(i));
      @(negedge clk);
    end
    check("fp_empty", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;
    wr(STATUS, 32'h0000_0004);

    // Unmapped access and W1C of err
    rd(32'h4000_0000);
    check("unmapped_rdata", bus.rdata, 32'h0);
    check("unmapped_err", 32'(err), 32'h1);
    rd(STATUS);
    check("status_err", bus.rdata, 32'h0000_000A);
    wr(STATUS, 32'h0000_0008);
    check("err_cleared", 32'(err), 32'h0);
    check("w1c_keeps_rdata", bus.rdata, 32'h0000_000A);
    wr(32'h0000_1000, 32'hFFFF_FFFF);
    check("ram_limit_err", 32'(err), 32'h1);
    check("unmapped_wr_keeps_rdata", bus.rdata, 32'h0000_000A);
    wr(STATUS, 32'h0000_0008);
    check("err_cleared2", 32'(err), 32'h0);

    // GPIO
    wr(GPIO, 32'h1234_5678);
    check("gpio_out", gpio, 32'h1234_5678);
    rd(GPIO);
    check("gpio_read", bus.rdata, 32'h1234_5678);

    // Reset mid-operation with a RAM write sampled on the reset edge
    wr(32'h0000_0020, 32'hCAFE_F00D);
    wr(CONSOLE, 32'h5A);
    bus.mem_en   = 1'b1;
    bus.mem_read = 1'b0;
    bus.addr     = 32'h0000_0020;
    bus.wdata    = 32'h1111_1111;
    rst          = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    bus.mem_en = 1'b0;
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_gpio", gpio, 32'h0);
    check("rst_fifo_empty", 32'(bus.tx_valid), 32'h0);
    rd(CYCLE);
    check("rst_cycle", bus.rdata, 32'h0);
    rd(32'h0000_0020);
    check("rst_no_ram_write", bus.rdata, 32'hCAFE_F00D);
    rd(STATUS);
    check("rst_status", bus.rdata, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
